// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV64 core.
// Sequences each instruction through fetch, decode, execute, memory and
// write-back steps and drives the datapath mux selects, write enables and
// the ALU operation select. Outputs are decoded from the state register;
// only mem_ready and zero qualify a few enables.
module multicycle_control #(
  parameter logic [6:0] OP_LOAD   = 7'b0000011,
  parameter logic [6:0] OP_STORE  = 7'b0100011,
  parameter logic [6:0] OP_RTYPE  = 7'b0110011,
  parameter logic [6:0] OP_BRANCH = 7'b1100011,
  parameter int         RETIRE_W  = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [6:0]          opcode,
  input  logic                zero,
  input  logic                mem_ready,
  output logic [1:0]          alu_op,
  output logic [1:0]          alu_src_a,
  output logic [1:0]          alu_src_b,
  output logic                i_or_d,
  output logic                mem_read,
  output logic                mem_write,
  output logic                ir_write,
  output logic                reg_write,
  output logic                mem_to_reg,
  output logic                pc_source,
  output logic                pc_en,
  output logic                illegal_instr,
  output logic [3:0]          state,
  output logic [RETIRE_W-1:0] retire_count
);

  localparam logic [3:0] S_FETCH     = 4'd0;
  localparam logic [3:0] S_DECODE    = 4'd1;
  localparam logic [3:0] S_MEM_ADDR  = 4'd2;
  localparam logic [3:0] S_MEM_READ  = 4'd3;
  localparam logic [3:0] S_MEM_WB    = 4'd4;
  localparam logic [3:0] S_MEM_WRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE   = 4'd6;
  localparam logic [3:0] S_R_WB      = 4'd7;
  localparam logic [3:0] S_BRANCH    = 4'd8;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_OLDPC = 2'b01;
  localparam logic [1:0] SRC_A_REG   = 2'b10;

  localparam logic [1:0] SRC_B_REG   = 2'b00;
  localparam logic [1:0] SRC_B_FOUR  = 2'b01;
  localparam logic [1:0] SRC_B_IMM   = 2'b10;

  logic [3:0] state_q;
  logic [3:0] state_next;
  logic       retire_now;
  logic       opcode_legal;

  assign state = state_q;

  // Decode which opcodes the core knows how to sequence.
  always_comb begin
    opcode_legal = 1'b0;
    if ((opcode == OP_LOAD) || (opcode == OP_STORE) ||
        (opcode == OP_RTYPE) || (opcode == OP_BRANCH)) begin
      opcode_legal = 1'b1;
    end
  end

  // Next-state selection; unreachable encodings fall back to FETCH.
  always_comb begin
    state_next = S_FETCH;
    case (state_q)
      S_FETCH: begin
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        if ((opcode == OP_LOAD) || (opcode == OP_STORE)) begin
          state_next = S_MEM_ADDR;
        end else if (opcode == OP_RTYPE) begin
          state_next = S_EXECUTE;
        end else if (opcode == OP_BRANCH) begin
          state_next = S_BRANCH;
        end else begin
          state_next = S_FETCH;
        end
      end
      S_MEM_ADDR: begin
        // DECODE only lets ld/sd through here, so anything not a load is a store.
        state_next = (opcode == OP_LOAD) ? S_MEM_READ : S_MEM_WRITE;
      end
      S_MEM_READ: begin
        state_next = mem_ready ? S_MEM_WB : S_MEM_READ;
      end
      S_MEM_WB: begin
        state_next = S_FETCH;
      end
      S_MEM_WRITE: begin
        state_next = mem_ready ? S_FETCH : S_MEM_WRITE;
      end
      S_EXECUTE: begin
        state_next = S_R_WB;
      end
      S_R_WB: begin
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        state_next = S_FETCH;
      end
      default: begin
        state_next = S_FETCH;
      end
    endcase
  end

  // Flag the clock on which an instruction completes and leaves the FSM.
  always_comb begin
    retire_now = 1'b0;
    case (state_q)
      S_MEM_WB:    retire_now = 1'b1;
      S_R_WB:      retire_now = 1'b1;
      S_BRANCH:    retire_now = 1'b1;
      S_MEM_WRITE: retire_now = mem_ready;
      default:     retire_now = 1'b0;
    endcase
  end

  // Moore output decode; reset masks every enable and request.
  always_comb begin
    alu_op        = ALU_ADD;
    alu_src_a     = SRC_A_PC;
    alu_src_b     = SRC_B_REG;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;
    pc_source     = 1'b0;
    pc_en         = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_read  = 1'b1;
        i_or_d    = 1'b0;
        alu_src_a = SRC_A_PC;
        alu_src_b = SRC_B_FOUR;
        alu_op    = ALU_ADD;
        // IR and PC+4 are only captured on the cycle the fetch completes.
        ir_write  = mem_ready;
        pc_en     = mem_ready;
      end
      S_DECODE: begin
        // Branch target OldPC + imm is computed speculatively into ALUOut.
        alu_src_a     = SRC_A_OLDPC;
        alu_src_b     = SRC_B_IMM;
        alu_op        = ALU_ADD;
        illegal_instr = ~opcode_legal;
      end
      S_MEM_ADDR: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_IMM;
        alu_op    = ALU_ADD;
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WRITE: begin
        // Held constant across stall cycles so the memory sees a stable request.
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_EXECUTE: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_FUNCT;
      end
      S_R_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b0;
      end
      S_BRANCH: begin
        alu_src_a = SRC_A_REG;
        alu_src_b = SRC_B_REG;
        alu_op    = ALU_SUB;
        pc_source = 1'b1;
        pc_en     = zero;
      end
      default: begin
        alu_op = ALU_ADD;
      end
    endcase
    if (reset) begin
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      pc_en         = 1'b0;
      illegal_instr = 1'b0;
    end
  end

  // State register and retired-instruction counter (wraps silently).
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_FETCH;
      retire_count <= '0;
    end else begin
      state_q <= state_next;
      if (retire_now) begin
        retire_count <= retire_count + {{(RETIRE_W-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control, built with a 4-bit retire counter.
module tb_multicycle_control;

  localparam int RW = 4;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  logic          clk = 1'b0;
  logic          reset;
  logic [6:0]    opcode;
  logic          zero;
  logic          mem_ready;
  logic [1:0]    alu_op;
  logic [1:0]    alu_src_a;
  logic [1:0]    alu_src_b;
  logic          i_or_d;
  logic          mem_read;
  logic          mem_write;
  logic          ir_write;
  logic          reg_write;
  logic          mem_to_reg;
  logic          pc_source;
  logic          pc_en;
  logic          illegal_instr;
  logic [3:0]    state;
  logic [RW-1:0] retire_count;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.RETIRE_W(RW)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .alu_op(alu_op), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .reg_write(reg_write), .mem_to_reg(mem_to_reg), .pc_source(pc_source),
    .pc_en(pc_en), .illegal_instr(illegal_instr), .state(state),
    .retire_count(retire_count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout state=%0d", state);
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; opcode = OP_RTYPE; zero = 1'b0; mem_ready = 1'b1;
    step(); step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state); end
    checks++; if (retire_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d want 0", retire_count); end
    checks++; if ({mem_read, mem_write, ir_write, reg_write, pc_en} !== 5'b0) begin
      errors++; $display("FAIL reset_enables got %b want 00000", {mem_read, mem_write, ir_write, reg_write, pc_en}); end
    reset = 1'b0; #1;
    checks++; if ({mem_read, ir_write, pc_en, alu_src_b} !== 5'b11101) begin
      errors++; $display("FAIL fetch_outputs got %b want 11101", {mem_read, ir_write, pc_en, alu_src_b}); end
  endtask

  task automatic test_fetch_stall();
    mem_ready = 1'b0; #1;
    checks++; if ({mem_read, ir_write, pc_en} !== 3'b100) begin
      errors++; $display("FAIL fetch_stall_en got %b want 100", {mem_read, ir_write, pc_en}); end
    step();
    checks++; if (state !== 4'd0) begin errors++; $display("FAIL fetch_stall_state got %0d want 0", state); end
    mem_ready = 1'b1;
  endtask

  task automatic test_rtype();
    opcode = OP_RTYPE; mem_ready = 1'b1;
    step();
    checks++; if ({state, alu_src_a, alu_src_b} !== {4'd1, 2'b01, 2'b10}) begin
      errors++; $display("FAIL rt_decode got %h want 1,1,2", {state, alu_src_a, alu_src_b}); end
    step();
    checks++; if ({state, alu_op, reg_write} !== {4'd6, 2'b10, 1'b0}) begin
      errors++; $display("FAIL rt_exec got %b want 0110100", {state, alu_op, reg_write}); end
    step();
    checks++; if ({state, reg_write, mem_to_reg} !== {4'd7, 1'b1, 1'b0}) begin
      errors++; $display("FAIL rt_wb got %b want 011110", {state, reg_write, mem_to_reg}); end
    step();
    checks++; if ({state, retire_count} !== {4'd0, 4'd1}) begin
      errors++; $display("FAIL rt_retire got state %0d count %0d want 0 1", state, retire_count); end
  endtask

  task automatic test_load_stall();
    int cycles = 0;
    int held = 0;
    opcode = OP_LOAD; mem_ready = 1'b1;
    step(); cycles++;
    step(); cycles++;
    checks++; if (state !== 4'd2) begin errors++; $display("FAIL ld_addr got %0d want 2", state); end
    mem_ready = 1'b0;
    step(); cycles++;
    for (int i = 0; i < 3; i++) begin
      if (state == 4'd3 && mem_read === 1'b1 && i_or_d === 1'b1) held++;
      step(); cycles++;
    end
    if (state == 4'd3 && mem_read === 1'b1) held++;
    checks++; if (held !== 4) begin errors++; $display("FAIL ld_mem_read_held got %0d want 4", held); end
    mem_ready = 1'b1;
    step(); cycles++;
    checks++; if ({state, reg_write, mem_to_reg} !== {4'd4, 1'b1, 1'b1}) begin
      errors++; $display("FAIL ld_wb got %b want 010011", {state, reg_write, mem_to_reg}); end
    step(); cycles++;
    checks++; if (cycles !== 8 || state !== 4'd0) begin
      errors++; $display("FAIL ld_latency got %0d cycles state %0d want 8 0", cycles, state); end
    checks++; if (retire_count !== 4'd2) begin errors++; $display("FAIL ld_count got %0d want 2", retire_count); end
  endtask

  task automatic test_branch(input logic z, input logic [RW-1:0] exp_count);
    opcode = OP_BRANCH; mem_ready = 1'b1; zero = z;
    step(); step();
    checks++; if ({state, alu_op, pc_source, pc_en} !== {4'd8, 2'b01, 1'b1, z}) begin
      errors++; $display("FAIL br_exec zero=%0b got %b want %b", z, {state, alu_op, pc_source, pc_en}, {4'd8, 2'b01, 1'b1, z}); end
    step();
    checks++; if ({state, retire_count} !== {4'd0, exp_count}) begin
      errors++; $display("FAIL br_retire got state %0d count %0d want 0 %0d", state, retire_count, exp_count); end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    opcode = 7'b1111111; mem_ready = 1'b1;
    step();
    checks++; if ({state, illegal_instr} !== {4'd1, 1'b1}) begin
      errors++; $display("FAIL ill_decode got %b want 00011", {state, illegal_instr}); end
    step();
    checks++; if ({state, illegal_instr, retire_count} !== {4'd0, 1'b0, 4'd4}) begin
      errors++; $display("FAIL ill_return got state %0d ill %0b count %0d want 0 0 4", state, illegal_instr, retire_count); end
  endtask

  task automatic test_store();
    opcode = OP_STORE; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0; #1;
    checks++; if ({state, mem_write, mem_read, i_or_d} !== {4'd5, 1'b1, 1'b0, 1'b1}) begin
      errors++; $display("FAIL sd_write got %b want 0101101", {state, mem_write, mem_read, i_or_d}); end
    step();
    checks++; if ({state, mem_write, retire_count} !== {4'd5, 1'b1, 4'd4}) begin
      errors++; $display("FAIL sd_stall got state %0d wr %0b count %0d want 5 1 4", state, mem_write, retire_count); end
    mem_ready = 1'b1;
    step();
    checks++; if ({state, retire_count} !== {4'd0, 4'd5}) begin
      errors++; $display("FAIL sd_retire got state %0d count %0d want 0 5", state, retire_count); end
  endtask

  task automatic test_reset_in_store_stall();
    opcode = OP_STORE; mem_ready = 1'b1;
    step(); step(); step();
    mem_ready = 1'b0;
    step();
    reset = 1'b1; #1;
    checks++; if (mem_write !== 1'b0) begin errors++; $display("FAIL rst_mw got %0b want 0", mem_write); end
    step();
    checks++; if ({state, retire_count} !== {4'd0, 4'd0}) begin
      errors++; $display("FAIL rst_stall got state %0d count %0d want 0 0", state, retire_count); end
    reset = 1'b0; mem_ready = 1'b1;
  endtask

  task automatic test_wrap();
    opcode = OP_RTYPE; mem_ready = 1'b1;
    for (int n = 0; n < 15; n++) begin
      step(); step(); step(); step();
    end
    checks++; if (retire_count !== 4'hF) begin errors++; $display("FAIL wrap_full got %0d want 15", retire_count); end
    step(); step(); step(); step();
    checks++; if ({state, retire_count} !== {4'd0, 4'd0}) begin
      errors++; $display("FAIL wrap_zero got state %0d count %0d want 0 0", state, retire_count); end
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_rtype();
    test_load_stall();
    test_branch(1'b1, 4'd3);
    test_branch(1'b0, 4'd4);
    test_illegal();
    test_store();
    test_reset_in_store_stall();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
